flappy_game_ctrl: RTL and testbench

Game sequencer for the Flappy Bird top level. Owns the play state (idle / flying / dead / paused), converts raw keypad activity into rate-limited single-cycle flap pulses, and keeps the running score and best score as 3-digit BCD.
- Display consumes `state`, `run` and `flap`.
- The 7-segment driver consumes `score_bcd` / `best_bcd` directly.

---
 rtl/flappy_game_ctrl_if.sv | 26 ++
 rtl/flappy_game_ctrl.sv | 149 ++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the Flappy Bird game sequencer and its surroundings.
// master: the side that drives frame/keypad/collision inputs and reads status.
// slave:  the game sequencer itself.
interface flappy_game_ctrl_if;
  logic        frame_tick;
  logic        key_ready;
  logic        pause_sw;
  logic        collide;
  logic        pipe_pass;
  logic [1:0]  state;
  logic        run;
  logic        flap;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic        new_best;

  modport master (
    output frame_tick, key_ready, pause_sw, collide, pipe_pass,
    input  state, run, flap, score_bcd, best_bcd, new_best
  );

  modport slave (
    input  frame_tick, key_ready, pause_sw, collide, pipe_pass,
    output state, run, flap, score_bcd, best_bcd, new_best
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: play state (idle/fly/dead/pause), rate-limited
// flap pulses from keypad edges, 3-digit BCD running score and best score.
// Optional feature macro: FLAPPY_BEST_SCORE_EN (best-score register and
// comparator; when undefined best_bcd is 0 and new_best is 0).
module flappy_game_ctrl #(
  parameter int unsigned DEAD_HOLD = 60,
  parameter int unsigned FLAP_GAP  = 4
) (
  input logic               clk,
  input logic               rst,
  flappy_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLY   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD  = 4'(FLAP_GAP);
  localparam logic [7:0] HOLD_LOAD = 8'(DEAD_HOLD);

  state_t      state_q;
  logic        run_q;
  logic        flap_q;
  logic        key_q;
  logic [11:0] score_q;
  logic [11:0] score_d;
  logic [3:0]  gap_q;
  logic [7:0]  hold_q;

  logic key_rise;
  logic enter_dead;
  logic restart;

  assign key_rise   = bus.key_ready & ~key_q;
  assign enter_dead = (state_q == ST_FLY) & bus.collide;
  assign restart    = (state_q == ST_DEAD) & key_rise & (hold_q == '0);

  // Saturating BCD increment of the score; digits stay within 0..9.
  always_comb begin
    score_d = score_q;
    if (score_q == 12'h999) begin
      score_d = score_q;
    end else if (score_q[3:0] != 4'd9) begin
      score_d[3:0] = score_q[3:0] + 4'd1;
    end else if (score_q[7:4] != 4'd9) begin
      score_d[7:4] = score_q[7:4] + 4'd1;
      score_d[3:0] = 4'd0;
    end else begin
      score_d[11:8] = score_q[11:8] + 4'd1;
      score_d[7:0]  = 8'h00;
    end
  end

  // Game state machine with registered outputs, counters and score.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      flap_q  <= 1'b0;
      key_q   <= 1'b1;
      score_q <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
    end else begin
      key_q  <= bus.key_ready;
      flap_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          score_q <= '0;
          if (key_rise) begin
            state_q <= ST_FLY;
            run_q   <= 1'b1;
            flap_q  <= 1'b1;
            gap_q   <= GAP_LOAD;
          end
        end
        ST_FLY: begin
          if (enter_dead) begin
            state_q <= ST_DEAD;
            run_q   <= 1'b0;
            hold_q  <= HOLD_LOAD;
          end else if (bus.pause_sw) begin
            state_q <= ST_PAUSE;
            run_q   <= 1'b0;
          end else begin
            // A refused press still lets the same-cycle frame tick count down.
            if (key_rise && (gap_q == '0)) begin
              flap_q <= 1'b1;
              gap_q  <= GAP_LOAD;
            end else if (bus.frame_tick && (gap_q != '0)) begin
              gap_q <= gap_q - 4'd1;
            end
            if (bus.pipe_pass) begin
              score_q <= score_d;
            end
          end
        end
        ST_DEAD: begin
          if (bus.frame_tick && (hold_q != '0)) begin
            hold_q <= hold_q - 8'd1;
          end
          if (restart) begin
            state_q <= ST_IDLE;
            score_q <= '0;
          end
        end
        ST_PAUSE: begin
          if (!bus.pause_sw) begin
            state_q <= ST_FLY;
            run_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.run       = run_q;
  assign bus.flap      = flap_q;
  assign bus.score_bcd = score_q;

`ifdef FLAPPY_BEST_SCORE_EN
  logic [11:0] best_q;
  logic        new_best_q;

  // Best score captured on the edge into DEAD; packed BCD compares as unsigned.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else if (enter_dead && (score_q > best_q)) begin
      best_q     <= score_q;
      new_best_q <= 1'b1;
    end else if (restart) begin
      new_best_q <= 1'b0;
    end
  end

  assign bus.best_bcd = best_q;
  assign bus.new_best = new_best_q;
`else
  assign bus.best_bcd = '0;
  assign bus.new_best = 1'b0;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl: stimulus pushes expected snapshots and
// flap cycles into queues; a negedge monitor pops and compares them.
module tb_flappy_game_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLY   = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flappy_game_ctrl_if bus_if ();

  flappy_game_ctrl #(.DEAD_HOLD(60), .FLAP_GAP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [1:0]  st;
    logic        run;
    logic [11:0] score;
    logic [11:0] best;
    logic        nb;
  } exp_t;

  exp_t        chk_q[$];
  int unsigned flap_q[$];

  function automatic logic [11:0] eb(input logic [11:0] v);
`ifdef FLAPPY_BEST_SCORE_EN
    return v;
`else
    return 12'h000 & v;
`endif
  endfunction

  function automatic logic enb(input logic v);
`ifdef FLAPPY_BEST_SCORE_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic miss(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: flap pulses and scheduled snapshots are compared as they appear.
  exp_t        m_e;
  int unsigned m_f;
  always @(negedge clk) begin
    if (bus_if.flap === 1'b1) begin
      if (flap_q.size() == 0) miss("flap_unexpected");
      else begin
        m_f = flap_q.pop_front();
        check("flap_cycle", cyc, m_f);
      end
    end else if (flap_q.size() > 0 && flap_q[0] <= cyc) begin
      m_f = flap_q.pop_front();
      miss("flap_missing");
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      m_e = chk_q.pop_front();
      if (m_e.cyc < cyc) miss({m_e.name, "_stale"});
      else begin
        check({m_e.name, ".state"}, bus_if.state, m_e.st);
        check({m_e.name, ".run"}, bus_if.run, m_e.run);
        check({m_e.name, ".score"}, bus_if.score_bcd, m_e.score);
        check({m_e.name, ".best"}, bus_if.best_bcd, m_e.best);
        check({m_e.name, ".new_best"}, bus_if.new_best, m_e.nb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [1:0] st, input logic run,
                            input logic [11:0] score, input logic [11:0] best, input logic nb);
    exp_t e;
    e.cyc = cyc; e.name = name; e.st = st; e.run = run;
    e.score = score; e.best = eb(best); e.nb = enb(nb);
    chk_q.push_back(e);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus_if.frame_tick = 1'b1;
      step();
      bus_if.frame_tick = 1'b0;
    end
  endtask

  task automatic press(input bit want_flap);
    bus_if.key_ready = 1'b1;
    if (want_flap) flap_q.push_back(cyc + 1);
    step();
    bus_if.key_ready = 1'b0;
    step();
  endtask

  task automatic pass_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus_if.pipe_pass = 1'b1;
      step();
      bus_if.pipe_pass = 1'b0;
      step();
    end
  endtask

  task automatic start_run(input string name, input logic [11:0] best);
    bus_if.key_ready = 1'b1;
    flap_q.push_back(cyc + 1);
    step();
    expect_now(name, S_FLY, 1'b1, 12'h000, best, 1'b0);
    bus_if.key_ready = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.frame_tick = 1'b0;
    bus_if.key_ready  = 1'b1;
    bus_if.pause_sw   = 1'b0;
    bus_if.collide    = 1'b0;
    bus_if.pipe_pass  = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    expect_now("reset", S_IDLE, 1'b0, 12'h000, 12'h000, 1'b0);
    step();
    expect_now("held_key_no_start", S_IDLE, 1'b0, 12'h000, 12'h000, 1'b0);
    bus_if.key_ready = 1'b0;
    step();

    // Start: key held 3 cycles gives one flap only.
    bus_if.key_ready = 1'b1;
    flap_q.push_back(cyc + 1);
    step();
    expect_now("start", S_FLY, 1'b1, 12'h000, 12'h000, 1'b0);
    step();
    step();
    expect_now("start_held", S_FLY, 1'b1, 12'h000, 12'h000, 1'b0);
    bus_if.key_ready = 1'b0;
    step();

    // Rate limit: press at frame 2 dropped, frame 4 accepted.
    tick(2);
    press(1'b0);
    tick(2);
    press(1'b1);
    // Tick and key together while gap == 1: refused, counter reaches 0.
    tick(3);
    bus_if.key_ready  = 1'b1;
    bus_if.frame_tick = 1'b1;
    step();
    bus_if.key_ready  = 1'b0;
    bus_if.frame_tick = 1'b0;
    step();
    press(1'b1);
    expect_now("after_flaps", S_FLY, 1'b1, 12'h000, 12'h000, 1'b0);

    // Score 7, then collide with simultaneous pipe_pass.
    pass_n(7);
    expect_now("score7", S_FLY, 1'b1, 12'h007, 12'h000, 1'b0);
    bus_if.collide   = 1'b1;
    bus_if.pipe_pass = 1'b1;
    step();
    bus_if.collide   = 1'b0;
    bus_if.pipe_pass = 1'b0;
    expect_now("death1", S_DEAD, 1'b0, 12'h007, 12'h007, 1'b1);
    bus_if.pause_sw = 1'b1;
    step();
    bus_if.pause_sw = 1'b0;
    expect_now("dead_pause_ignored", S_DEAD, 1'b0, 12'h007, 12'h007, 1'b1);

    // Restart hold.
    tick(30);
    press(1'b0);
    expect_now("hold30", S_DEAD, 1'b0, 12'h007, 12'h007, 1'b1);
    tick(29);
    press(1'b0);
    expect_now("hold1", S_DEAD, 1'b0, 12'h007, 12'h007, 1'b1);
    tick(1);
    bus_if.key_ready = 1'b1;
    step();
    expect_now("restart1", S_IDLE, 1'b0, 12'h000, 12'h007, 1'b0);
    bus_if.key_ready = 1'b0;
    step();

    // Second run dies at 3 via collide + pause_sw.
    start_run("start2", 12'h007);
    pass_n(3);
    bus_if.collide  = 1'b1;
    bus_if.pause_sw = 1'b1;
    step();
    bus_if.collide  = 1'b0;
    bus_if.pause_sw = 1'b0;
    expect_now("death2", S_DEAD, 1'b0, 12'h003, 12'h007, 1'b0);
    tick(60);
    bus_if.key_ready = 1'b1;
    step();
    expect_now("restart2", S_IDLE, 1'b0, 12'h000, 12'h007, 1'b0);
    bus_if.key_ready = 1'b0;
    step();

    // Third run: carry and saturation.
    start_run("start3", 12'h007);
    pass_n(9);
    expect_now("score9", S_FLY, 1'b1, 12'h009, 12'h007, 1'b0);
    pass_n(1);
    expect_now("score10", S_FLY, 1'b1, 12'h010, 12'h007, 1'b0);
    pass_n(9);
    expect_now("score19", S_FLY, 1'b1, 12'h019, 12'h007, 1'b0);
    pass_n(80);
    expect_now("score99", S_FLY, 1'b1, 12'h099, 12'h007, 1'b0);
    pass_n(1);
    expect_now("score100", S_FLY, 1'b1, 12'h100, 12'h007, 1'b0);
    pass_n(899);
    expect_now("score999", S_FLY, 1'b1, 12'h999, 12'h007, 1'b0);
    pass_n(1);
    expect_now("score_sat", S_FLY, 1'b1, 12'h999, 12'h007, 1'b0);
    bus_if.collide = 1'b1;
    step();
    bus_if.collide = 1'b0;
    expect_now("death3", S_DEAD, 1'b0, 12'h999, 12'h999, 1'b1);
    tick(60);
    bus_if.key_ready = 1'b1;
    step();
    expect_now("restart3", S_IDLE, 1'b0, 12'h000, 12'h999, 1'b0);
    bus_if.key_ready = 1'b0;
    step();

    // Pause: events ignored, gap counter frozen, reset mid-pause.
    start_run("start4", 12'h999);
    bus_if.pause_sw = 1'b1;
    step();
    expect_now("paused", S_PAUSE, 1'b0, 12'h000, 12'h999, 1'b0);
    bus_if.collide   = 1'b1;
    bus_if.pipe_pass = 1'b1;
    step();
    bus_if.collide   = 1'b0;
    bus_if.pipe_pass = 1'b0;
    press(1'b0);
    tick(4);
    expect_now("paused_ignored", S_PAUSE, 1'b0, 12'h000, 12'h999, 1'b0);
    bus_if.pause_sw = 1'b0;
    step();
    expect_now("unpaused", S_FLY, 1'b1, 12'h000, 12'h999, 1'b0);
    press(1'b0);
    tick(4);
    press(1'b1);
    bus_if.pause_sw = 1'b1;
    step();
    expect_now("paused2", S_PAUSE, 1'b0, 12'h000, 12'h999, 1'b0);
    rst = 1'b1;
    step();
    expect_now("reset_mid_pause", S_IDLE, 1'b0, 12'h000, 12'h000, 1'b0);
    rst = 1'b0;
    bus_if.pause_sw = 1'b0;
    step();
    expect_now("after_reset", S_IDLE, 1'b0, 12'h000, 12'h000, 1'b0);

    repeat (2) step();
    #5;
    while (flap_q.size() > 0) begin
      void'(flap_q.pop_front());
      miss("flap_never_seen");
    end
    while (chk_q.size() > 0) begin
      void'(chk_q.pop_front());
      miss("snapshot_never_checked");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
